// File: rtl/latch_chain_pkg.sv
// Shared types and widths for the latch-chain loader.
package latch_chain_pkg;

   localparam int CHAIN_WIDTH = 48;
   localparam int CHAIN_DEPTH = 8;
   localparam int IDX_W = (CHAIN_DEPTH > 1) ? $clog2(CHAIN_DEPTH) : 1;
   localparam int CNT_W = $clog2(CHAIN_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP,
      FLUSH
   } state_t;

endpackage

// File: rtl/latch_shift_reg.sv
// Behavioural DEPTH-stage transparent-latch shift chain driven by the loader.
// Stage 0 takes the data input; stage i takes stage i-1 while its enable is high.
module latch_shift_reg #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 8
) (
   input  logic [WIDTH-1:0]             d,
   input  logic [DEPTH-1:0]             en,
   input  logic                         rst_n,
   output logic [DEPTH-1:0][WIDTH-1:0]  stages
);

   always_latch begin
      for (int i = 0; i < DEPTH; i++) begin
         if (!rst_n)
            stages[i] <= '0;
         else if (en[i])
            stages[i] <= (i == 0) ? d : stages[(i == 0) ? 0 : i - 1];
      end
   end

endmodule

// File: rtl/latch_chain_loader.sv
// Loads words into a latch shift chain with one-hot, deepest-first enables and flushes it.
// Define LATCH_GAP_EN to insert an idle cycle between consecutive stage strobes.
module latch_chain_loader
   import latch_chain_pkg::*;
#(
   parameter int WIDTH = CHAIN_WIDTH,
   parameter int DEPTH = CHAIN_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       clr_req,
   output logic [WIDTH-1:0]           latch_data,
   output logic [DEPTH-1:0]           latch_en,
   output logic                       latch_rst_n,
   output logic                       busy,
   output logic                       frame_valid,
   output logic [$clog2(DEPTH+1)-1:0] word_cnt
);

   localparam int SI_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WC_W = $clog2(DEPTH + 1);
   localparam logic [SI_W-1:0] LAST_STAGE = SI_W'(DEPTH - 1);
   localparam logic [WC_W-1:0] FULL       = WC_W'(DEPTH);

   state_t            state, state_nxt;
   logic [SI_W-1:0]   idx, idx_nxt;
   logic [SI_W-1:0]   flush_cnt, flush_cnt_nxt;
   logic [WIDTH-1:0]  data_nxt;
   logic [DEPTH-1:0]  en_nxt;
   logic [WC_W-1:0]   cnt_nxt;
   logic              rst_n_nxt, frame_nxt;
   logic              clr_pend, clr_pend_nxt;

   // A pending clear blocks acceptance so the flush always wins the next IDLE cycle.
   assign in_ready = (state == IDLE) && !clr_pend;
   assign busy     = (state != IDLE);

   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      flush_cnt_nxt = flush_cnt;
      data_nxt      = latch_data;
      en_nxt        = '0;
      rst_n_nxt     = latch_rst_n;
      frame_nxt     = frame_valid;
      cnt_nxt       = word_cnt;
      clr_pend_nxt  = clr_pend || (clr_req && (state != IDLE));

      case (state)
         IDLE: begin
            if (clr_pend || clr_req) begin
               state_nxt     = FLUSH;
               clr_pend_nxt  = 1'b0;
               data_nxt      = '0;
               rst_n_nxt     = 1'b0;
               flush_cnt_nxt = '0;
            end else if (in_valid) begin
               data_nxt           = in_data;
               idx_nxt            = LAST_STAGE;
               en_nxt[LAST_STAGE] = 1'b1;
               state_nxt          = SHIFT;
            end
         end
         SHIFT: begin
            if (idx == '0) begin
               state_nxt = IDLE;
               if (word_cnt != FULL)
                  cnt_nxt = word_cnt + 1'b1;
               frame_nxt = (cnt_nxt == FULL);
            end else begin
               idx_nxt = idx - 1'b1;
`ifdef LATCH_GAP_EN
               state_nxt = GAP;
`else
               en_nxt[idx_nxt] = 1'b1;
`endif
            end
         end
`ifdef LATCH_GAP_EN
         GAP: begin
            en_nxt[idx] = 1'b1;
            state_nxt   = SHIFT;
         end
`endif
         FLUSH: begin
            if (flush_cnt == LAST_STAGE) begin
               rst_n_nxt = 1'b1;
               cnt_nxt   = '0;
               frame_nxt = 1'b0;
               state_nxt = IDLE;
            end else begin
               flush_cnt_nxt = flush_cnt + 1'b1;
            end
         end
         default: state_nxt = FLUSH;
      endcase
   end

   // Chain contents are unknown out of reset, so reset parks the block in FLUSH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FLUSH;
         idx         <= '0;
         flush_cnt   <= '0;
         latch_data  <= '0;
         latch_en    <= '0;
         latch_rst_n <= 1'b0;
         frame_valid <= 1'b0;
         word_cnt    <= '0;
         clr_pend    <= 1'b0;
      end else begin
         state       <= state_nxt;
         idx         <= idx_nxt;
         flush_cnt   <= flush_cnt_nxt;
         latch_data  <= data_nxt;
         latch_en    <= en_nxt;
         latch_rst_n <= rst_n_nxt;
         frame_valid <= frame_nxt;
         word_cnt    <= cnt_nxt;
         clr_pend    <= clr_pend_nxt;
      end
   end

endmodule

// File: tb/tb_latch_chain_loader.sv
// Directed self-checking bench for latch_chain_loader driving a latch_shift_reg load.
module tb_latch_chain_loader;
   import latch_chain_pkg::*;

   localparam int WIDTH = 48;
   localparam int DEPTH = 8;
`ifdef LATCH_GAP_EN
   localparam int LOAD_CYC = 2 * DEPTH - 1;
`else
   localparam int LOAD_CYC = DEPTH;
`endif

   logic                             clk = 1'b0;
   logic                             rst = 1'b1;
   logic                             in_valid = 1'b0;
   logic                             clr_req = 1'b0;
   logic [WIDTH-1:0]                 in_data = '0;
   logic                             in_ready, latch_rst_n, busy, frame_valid;
   logic [WIDTH-1:0]                 latch_data;
   logic [DEPTH-1:0]                 latch_en;
   logic [CNT_W-1:0]                 word_cnt;
   logic [DEPTH-1:0][WIDTH-1:0]      stages;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   latch_chain_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .clr_req(clr_req), .latch_data(latch_data),
      .latch_en(latch_en), .latch_rst_n(latch_rst_n), .busy(busy),
      .frame_valid(frame_valid), .word_cnt(word_cnt)
   );

   latch_shift_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chain (
      .d(latch_data), .en(latch_en), .rst_n(latch_rst_n), .stages(stages)
   );

   // Every-cycle invariants: one-hot enables, none during reset, data quiet around stage 0.
   logic [WIDTH-1:0] prev_data = '0;
   logic             prev_en0 = 1'b0;
   always @(negedge clk) begin
      tests_run++;
      if ($countones(latch_en) > 1 || (!latch_rst_n && latch_en != '0)) begin
         tests_failed++;
         $display("[TB] FAIL enable_invariant: latch_en=%h latch_rst_n=%b, required one-hot/zero and zero while rst_n low",
                  latch_en, latch_rst_n);
      end
      if (!rst && (latch_en[0] || prev_en0)) begin
         tests_run++;
         if (latch_data !== prev_data) begin
            tests_failed++;
            $display("[TB] FAIL data_stable: latch_data=%h, required %h", latch_data, prev_data);
         end
      end
      prev_data = latch_data;
      prev_en0  = latch_en[0];
   end

   task automatic send_word(input logic [WIDTH-1:0] w, output bit timed_out);
      int n = 0;
      timed_out = 1'b0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) timed_out = 1'b1;
      else begin
         in_valid = 1'b1;
         in_data  = w;
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(output bit timed_out);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      timed_out = !in_ready;
   endtask

   task automatic test_reset();
      int low = 0;
      int n = 0;
      bit data_bad = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({in_ready, busy, latch_rst_n, frame_valid} !== 4'b0100) begin
         tests_failed++;
         $display("[TB] FAIL reset_flags: {ready,busy,rst_n,fv}=%b, required 0100",
                  {in_ready, busy, latch_rst_n, frame_valid});
      end
      tests_run++;
      if (latch_data !== '0 || latch_en !== '0 || word_cnt !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_values: data=%h en=%h cnt=%0d, required all zero", latch_data, latch_en, word_cnt);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      while (!latch_rst_n && n < 30) begin
         if (latch_data !== '0) data_bad = 1'b1;
         low++;
         n++;
         @(negedge clk);
      end
      tests_run++;
      if (low != DEPTH) begin
         tests_failed++;
         $display("[TB] FAIL reset_flush_len: rst_n low %0d cycles, required %0d", low, DEPTH);
      end
      tests_run++;
      if (data_bad) begin
         tests_failed++;
         $display("[TB] FAIL reset_flush_data: latch_data nonzero during flush, required 0");
      end
      tests_run++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || word_cnt !== '0 || frame_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_idle: ready=%b busy=%b cnt=%0d fv=%b, required 1 0 0 0",
                  in_ready, busy, word_cnt, frame_valid);
      end
   endtask

   task automatic test_single_word();
      bit to;
      int j;
      logic [DEPTH-1:0] exp_en;
      logic [WIDTH-1:0] w = 48'hA5A5_0000_1234;
      send_word(w, to);
      tests_run++;
      if (to) begin
         tests_failed++;
         $display("[TB] FAIL single_accept: in_ready never rose, required 1");
      end
      for (int k = 1; k <= LOAD_CYC; k++) begin
         @(negedge clk);
         exp_en = '0;
`ifdef LATCH_GAP_EN
         j = (k - 1) / 2;
         if (k % 2 == 1) exp_en[DEPTH-1-j] = 1'b1;
`else
         j = k - 1;
         exp_en[DEPTH-1-j] = 1'b1;
`endif
         tests_run++;
         if (latch_en !== exp_en || in_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_strobe t+%0d: en=%h ready=%b, required en=%h ready=0",
                     k, latch_en, in_ready, exp_en);
         end
      end
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1 || latch_en !== '0) begin
         tests_failed++;
         $display("[TB] FAIL single_ready: ready=%b en=%h at t+%0d, required 1 and 0", in_ready, latch_en, LOAD_CYC + 1);
      end
      tests_run++;
      if (stages[0] !== w || word_cnt !== CNT_W'(1) || frame_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL single_result: stage0=%h cnt=%0d fv=%b, required %h 1 0", stages[0], word_cnt, frame_valid, w);
      end
   endtask

   task automatic test_frame_load();
      bit to;
      @(negedge clk);
      clr_req = 1'b1;
      @(posedge clk);
      #1 clr_req = 1'b0;
      wait_idle(to);
      tests_run++;
      if (to || word_cnt !== '0) begin
         tests_failed++;
         $display("[TB] FAIL frame_preclear: timeout=%b cnt=%0d, required 0 0", to, word_cnt);
      end
      for (int i = 1; i <= DEPTH; i++) begin
         send_word(WIDTH'(i), to);
         wait_idle(to);
         tests_run++;
         if (to || word_cnt !== CNT_W'(i) || frame_valid !== (i == DEPTH)) begin
            tests_failed++;
            $display("[TB] FAIL frame_word%0d: timeout=%b cnt=%0d fv=%b, required 0 %0d %b",
                     i, to, word_cnt, frame_valid, i, (i == DEPTH));
         end
      end
      tests_run++;
      if (stages[0] !== WIDTH'(8) || stages[DEPTH-1] !== WIDTH'(1)) begin
         tests_failed++;
         $display("[TB] FAIL frame_contents: stage0=%h stage7=%h, required 8 and 1", stages[0], stages[DEPTH-1]);
      end
      send_word(WIDTH'(9), to);
      wait_idle(to);
      tests_run++;
      if (to || stages[DEPTH-1] !== WIDTH'(2) || stages[0] !== WIDTH'(9) || word_cnt !== CNT_W'(DEPTH) || frame_valid !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL frame_overflow: stage7=%h stage0=%h cnt=%0d fv=%b, required 2 9 8 1",
                  stages[DEPTH-1], stages[0], word_cnt, frame_valid);
      end
   endtask

   task automatic test_clr_with_valid();
      bit to;
      int low = 0;
      int n = 0;
      logic [WIDTH-1:0] w = 48'hDEAD_BEEF_0001;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w;
      clr_req  = 1'b1;
      @(posedge clk);
      #1 clr_req = 1'b0;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0 || latch_data !== '0 || latch_rst_n !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL clr_priority: ready=%b data=%h rst_n=%b, required 0 0 0", in_ready, latch_data, latch_rst_n);
      end
      in_valid = 1'b0;
      while (!latch_rst_n && n < 30) begin
         low++;
         n++;
         @(negedge clk);
      end
      tests_run++;
      if (low != DEPTH) begin
         tests_failed++;
         $display("[TB] FAIL clr_flush_len: rst_n low %0d cycles, required %0d", low, DEPTH);
      end
      tests_run++;
      if (stages !== '0 || frame_valid !== 1'b0 || word_cnt !== '0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL clr_result: stages_nonzero=%b fv=%b cnt=%0d ready=%b, required 0 0 0 1",
                  stages != '0, frame_valid, word_cnt, in_ready);
      end
      send_word(w, to);
      wait_idle(to);
      tests_run++;
      if (to || stages[0] !== w || word_cnt !== CNT_W'(1)) begin
         tests_failed++;
         $display("[TB] FAIL clr_represent: stage0=%h cnt=%0d, required %h 1", stages[0], word_cnt, w);
      end
   endtask

   task automatic test_clr_mid_shift();
      bit to;
      bit saw_en0 = 1'b0;
      int low = 0;
      int n = 0;
      logic [WIDTH-1:0] cap = '0;
      logic [WIDTH-1:0] w = 48'h5555_AAAA_0F0F;
      send_word(w, to);
      @(negedge clk);
      while (latch_en !== 8'h10 && n < 40) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (latch_en !== 8'h10) begin
         tests_failed++;
         $display("[TB] FAIL mid_stage4: latch_en=%h, required 10", latch_en);
      end
      clr_req = 1'b1;
      @(posedge clk);
      #1 clr_req = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (latch_en[0]) begin
            saw_en0 = 1'b1;
            cap = stages[0];
         end
         if (!latch_rst_n) low++;
      end while (!in_ready && n < 60);
      tests_run++;
      if (!saw_en0 || cap !== w) begin
         tests_failed++;
         $display("[TB] FAIL mid_complete: saw_en0=%b stage0=%h, required 1 %h", saw_en0, cap, w);
      end
      tests_run++;
      if (low != DEPTH) begin
         tests_failed++;
         $display("[TB] FAIL mid_flush_len: rst_n low %0d cycles, required %0d", low, DEPTH);
      end
      tests_run++;
      if (stages !== '0 || word_cnt !== '0 || frame_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL mid_result: stages_nonzero=%b cnt=%0d fv=%b ready=%b, required 0 0 0 1",
                  stages != '0, word_cnt, frame_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      bit to;
      int n = 0;
      send_word(48'h0000_0000_1234, to);
      @(negedge clk);
      while (latch_en !== 8'h20 && n < 40) begin
         @(negedge clk);
         n++;
      end
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if ({in_ready, busy, latch_rst_n, frame_valid} !== 4'b0100 || latch_en !== '0 || latch_data !== '0 || word_cnt !== '0) begin
         tests_failed++;
         $display("[TB] FAIL async_reset: ready=%b busy=%b rst_n=%b fv=%b en=%h data=%h cnt=%0d, required 0 1 0 0 0 0 0",
                  in_ready, busy, latch_rst_n, frame_valid, latch_en, latch_data, word_cnt);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      wait_idle(to);
      tests_run++;
      if (to || stages !== '0 || word_cnt !== '0) begin
         tests_failed++;
         $display("[TB] FAIL async_reflush: timeout=%b stages_nonzero=%b cnt=%0d, required 0 0 0",
                  to, stages != '0, word_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_frame_load();
      test_clr_with_valid();
      test_clr_mid_shift();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/latch_chain_loader.md
Name: latch_chain_loader

Overview:
- Sequencer that loads WIDTH-bit configuration words into a DEPTH-stage latch shift chain.
- Accepts words over a valid/ready handshake and holds each on the chain's data input.
- Generates one-hot latch enables from the deepest stage down to stage 0, so no two stages are ever transparent together.
- Also performs chain flush-to-zero and reports when a full frame of DEPTH words is resident.

Parameters:
- WIDTH, 48, bits per chain word.
- DEPTH, 8, number of chain stages and words per frame.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  loader can accept a word.
- in_data  in  WIDTH  word to load.
- clr_req  in  1  one-cycle request to flush the chain to zero.
- latch_data  out  WIDTH  drives the chain data input; registered and held.
- latch_en  out  DEPTH  one-hot or zero stage enables; registered.
- latch_rst_n  out  1  drives the chain rst_n (all stages transparent when low); registered.
- busy  out  1  a load or flush is in progress.
- frame_valid  out  1  DEPTH words have been loaded since the last clear or reset.
- word_cnt  out  $clog2(DEPTH+1)  words loaded since the last clear, saturating at DEPTH.

Behaviour:
- Reset values: in_ready=0, latch_data=0, latch_en=0, latch_rst_n=0, busy=1, frame_valid=0, word_cnt=0.
- Release from reset enters FLUSH, because chain contents are unknown.
- States: IDLE, SHIFT, GAP (only with the optional feature), FLUSH.
- IDLE:
  - in_ready=1, busy=0.
  - clr_req has priority over in_valid. If both are high in the same cycle, the word is NOT accepted: in_ready drops on the next cycle and the bench must re-present the word.
  - Acceptance: in_valid & in_ready at edge t. Then latch_data<=in_data and the stage index<=DEPTH-1, and the block goes to SHIFT.
- SHIFT:
  - latch_en = one-hot of the stage index, asserted for exactly one cycle per stage.
  - Order is DEPTH-1, DEPTH-2, ..., 0, so latch_en[DEPTH-1] is high in cycle t+1 and latch_en[0] in cycle t+DEPTH.
  - After stage 0: word_cnt++ (saturating at DEPTH), frame_valid=(word_cnt==DEPTH), return to IDLE.
  - in_ready returns high at cycle t+DEPTH+1.
  - latch_data remains stable from t+1 until the next acceptance.
- FLUSH:
  - latch_data<=0, then latch_rst_n=0 for DEPTH consecutive cycles so zero ripples through every stage. latch_en stays 0 throughout.
  - Then latch_rst_n=1, word_cnt=0, frame_valid=0, return to IDLE.
  - clr_req during SHIFT or FLUSH is latched as pending. It is serviced on return to IDLE, before any new word.
- Loading beyond DEPTH words is legal: the oldest word is shifted out, word_cnt stays at DEPTH and frame_valid stays 1.
- Invariants:
  - At most one latch_en bit is high in any cycle.
  - latch_en is never nonzero while latch_rst_n=0.
  - latch_data never changes in a cycle where latch_en[0] is high, or in the cycle after it.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous), and the block re-flushes on release.

Optional Feature:
- Macro: LATCH_GAP_EN.
- Defined: a GAP state inserts one idle cycle (latch_en=0) after every SHIFT strobe except the last. This gives non-overlap margin between adjacent stage enables.
  - Load time becomes 2*DEPTH-1 cycles: latch_en[0] at t+2*DEPTH-1, in_ready back at t+2*DEPTH.
  - FLUSH is unchanged.
- Undefined: strobes are back-to-back as described above, and the GAP state does not exist.

Decomposition:
- Package latch_chain_pkg:
  - state enum (IDLE, SHIFT, GAP, FLUSH);
  - localparam for the stage-index width $clog2(DEPTH);
  - localparam for the count width $clog2(DEPTH+1).
- No sub-module; the one-hot stage decode is inline.
- The bench instantiates latch_shift_reg as the load and connects latch_data, latch_en and latch_rst_n to it.

Test Plan:
- Reset release -> latch_rst_n low for exactly 8 cycles with latch_data=0, then in_ready=1, word_cnt=0, frame_valid=0.
- Single word 48'hA5A5_0000_1234 accepted at t -> latch_en = 8'h80, 8'h40, ... 8'h01 at t+1..t+8; stage 0 of the chain = 48'hA5A5_0000_1234; word_cnt=1; in_ready at t+9.
- Load 8 words, 48'h1 through 48'h8, back-to-back -> frame_valid=1 after the eighth; chain stage 0 = 8, stage 7 = 1. Then a ninth word 48'h9 -> stage 7 = 2, word_cnt stays 8.
- clr_req and in_valid asserted together in IDLE -> word not accepted, FLUSH runs; afterwards all stages are 0 and frame_valid=0.
- clr_req pulsed mid-SHIFT at stage 4 -> the current word completes, then FLUSH runs; no latch_en bit is high while latch_rst_n=0.
- With LATCH_GAP_EN defined: one word -> latch_en strobes at t+1, t+3, ... t+15 with zeros between them; in_ready back at t+16.
